keypad_emulator: RTL and testbench



---
 rtl/keypad_pkg.sv | 27 ++
 rtl/keypad_emulator.sv | 163 ++++++++++++++++
 tb/tb_keypad_emulator.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/keypad_pkg.sv
// keypad_pkg: constants, types and helper functions shared by the keypad
// emulator and the keypad scanner.
//   kp_emu_state_t : emulator press-sequence states
//   ROW_IDLE       : row value when no key is sensed
//   code_to_row()  : one-hot row select for a 4-bit button code (code[3:2])
//   code_to_col()  : one-hot column select for a 4-bit button code (code[1:0])
package keypad_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_B_PRESS   = 3'd1,
    ST_HOLD      = 3'd2,
    ST_B_RELEASE = 3'd3,
    ST_GAP       = 3'd4
  } kp_emu_state_t;

  localparam logic [3:0] ROW_IDLE = 4'b1111;

  function automatic logic [3:0] code_to_row(input logic [3:0] code);
    return 4'b0001 << code[3:2];
  endfunction

  function automatic logic [3:0] code_to_col(input logic [3:0] code);
    return 4'b0001 << code[1:0];
  endfunction

endpackage

// File: rtl/keypad_emulator.sv
// keypad_emulator: responder side of a 4x4 column-drive / row-sense keypad.
// Accepts a button code over valid/ready and plays back one complete press:
// press bounce, solid hold, release bounce and a quiet gap, then pulses done.
//
// Parameters
//   HOLD_CYCLES   : cycles of solid contact (>= 1)
//   BOUNCE_CYCLES : cycles of each bounce phase (0 = no bouncing)
//   GAP_CYCLES    : cycles of open contact after release (>= 1)
//   CNT_W         : phase counter width (every cycle parameter < 2**CNT_W)
// Ports
//   clk       in   clock, rising edge
//   rst       in   asynchronous active-high reset
//   key_valid in   press request offered
//   key_code  in   button index, row = code[3:2], column = code[1:0]
//   key_ready out  emulator idle and able to accept a request
//   col       in   column drive from scanner, active-high
//   row       out  row sense, 4'b1111 when not sensed, else one-hot row
//   contact   out  internal switch state (registered)
//   busy      out  press sequence in progress
//   done      out  one-cycle pulse on return to idle
module keypad_emulator
  import keypad_pkg::*;
#(
  parameter int HOLD_CYCLES   = 16,
  parameter int BOUNCE_CYCLES = 4,
  parameter int GAP_CYCLES    = 8,
  parameter int CNT_W         = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  output logic       key_ready,
  input  logic [3:0] col,
  output logic [3:0] row,
  output logic       contact,
  output logic       busy,
  output logic       done
);

  // Counter load values: each phase lasts (load + 1) cycles.
  localparam bit             HAS_BOUNCE = (BOUNCE_CYCLES > 0);
  localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LD   = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] BOUNCE_LD =
    HAS_BOUNCE ? CNT_W'(BOUNCE_CYCLES - 1) : '0;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  kp_emu_state_t    state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       code_q, code_d;
  logic             contact_q, contact_d;
  logic             done_q, done_d;
  logic             cnt_zero;

  assign cnt_zero = (cnt_q == '0);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      code_q    <= 4'd0;
      contact_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      code_q    <= code_d;
      contact_q <= contact_d;
      done_q    <= done_d;
    end
  end

  // Next-state logic: the counter is reloaded on every phase entry and the
  // phase ends on the cycle the counter reads zero.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    code_d  = code_q;
    unique case (state_q)
      ST_IDLE: begin
        if (key_valid) begin
          code_d = key_code;
          if (HAS_BOUNCE) begin
            state_d = ST_B_PRESS;
            cnt_d   = BOUNCE_LD;
          end else begin
            state_d = ST_HOLD;
            cnt_d   = HOLD_LD;
          end
        end
      end
      ST_B_PRESS: begin
        if (cnt_zero) begin
          state_d = ST_HOLD;
          cnt_d   = HOLD_LD;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      ST_HOLD: begin
        if (cnt_zero) begin
          if (HAS_BOUNCE) begin
            state_d = ST_B_RELEASE;
            cnt_d   = BOUNCE_LD;
          end else begin
            state_d = ST_GAP;
            cnt_d   = GAP_LD;
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      ST_B_RELEASE: begin
        if (cnt_zero) begin
          state_d = ST_GAP;
          cnt_d   = GAP_LD;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      ST_GAP: begin
        if (cnt_zero) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Output logic. contact is registered, so it is computed from the state and
  // counter being entered; in each cycle it then matches the current phase.
  // Press bounce ends open (cnt[0]=0 on the last cycle), release bounce ends
  // closed, so the hold edge and the gap edge are both clean transitions.
  always_comb begin
    contact_d = 1'b0;
    done_d    = (state_q == ST_GAP) && cnt_zero;
    unique case (state_d)
      ST_B_PRESS:   contact_d = cnt_d[0];
      ST_HOLD:      contact_d = 1'b1;
      ST_B_RELEASE: contact_d = ~cnt_d[0];
      default:      contact_d = 1'b0;
    endcase
  end

  assign busy      = (state_q != ST_IDLE);
  assign key_ready = (state_q == ST_IDLE);
  assign contact   = contact_q;
  assign done      = done_q;

  // Deliberately combinational from col: the scanner sees its own column
  // drive reflected in the same cycle, like a real switch matrix.
  assign row = (contact_q && |(col & code_to_col(code_q))) ? code_to_row(code_q)
                                                           : ROW_IDLE;

endmodule

// File: tb/tb_keypad_emulator.sv
// Testbench for keypad_emulator. Main DUT uses default parameters and is
// checked every cycle by a scoreboard monitor; a second instance without
// bouncing is exercised with directed presses.
module tb_keypad_emulator;

  localparam int HOLD   = 16;
  localparam int BOUNCE = 4;
  localparam int GAP    = 8;
  localparam int LEN    = 2 * BOUNCE + HOLD + GAP;
  localparam int LEN_NB = HOLD + GAP;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       key_valid = 1'b0;
  logic [3:0] key_code = 4'd0;
  logic [3:0] col = 4'hF;
  logic       key_ready, contact, busy, done;
  logic [3:0] row;

  logic       nb_valid = 1'b0;
  logic [3:0] nb_code = 4'd0;
  logic [3:0] nb_col = 4'hF;
  logic       nb_ready, nb_contact, nb_busy, nb_done;
  logic [3:0] nb_row;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  keypad_emulator dut (
    .clk(clk), .rst(rst), .key_valid(key_valid), .key_code(key_code),
    .key_ready(key_ready), .col(col), .row(row), .contact(contact),
    .busy(busy), .done(done)
  );

  keypad_emulator #(.HOLD_CYCLES(HOLD), .BOUNCE_CYCLES(0), .GAP_CYCLES(GAP)) dut_nb (
    .clk(clk), .rst(rst), .key_valid(nb_valid), .key_code(nb_code),
    .key_ready(nb_ready), .col(nb_col), .row(nb_row), .contact(nb_contact),
    .busy(nb_busy), .done(nb_done)
  );

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference contact waveform for one press, indexed by busy cycle:
  // press bounce alternates and finishes open, hold is solid, release bounce
  // alternates and finishes closed, gap is open.
  function automatic logic [LEN-1:0] make_wave();
    logic [LEN-1:0] w;
    w = '0;
    for (int i = 0; i < BOUNCE; i++) begin
      w[i]                 = ((BOUNCE - 1 - i) % 2) == 1;
      w[BOUNCE + HOLD + i] = ((BOUNCE - 1 - i) % 2) == 0;
    end
    for (int i = 0; i < HOLD; i++) w[BOUNCE + i] = 1'b1;
    return w;
  endfunction

  function automatic logic [3:0] exp_row(input logic c, input logic [3:0] code,
                                         input logic [3:0] cv);
    logic [3:0] one;
    one = 4'd1;
    if (c && cv[code % 4]) return one << (code / 4);
    return 4'hF;
  endfunction

  // ---------------- scoreboard ----------------
  logic [LEN-1:0] exp_wave;
  logic [3:0]     exp_q[$];
  logic           mon_active = 1'b0;
  logic           mon_done_next = 1'b0;
  int             mon_pos = 0;
  logic [3:0]     mon_code = 4'd0;
  logic           m_ec, m_eb, m_ed;

  initial exp_wave = make_wave();

  always @(negedge clk) begin
    if (rst) begin
      mon_active    = 1'b0;
      mon_done_next = 1'b0;
      mon_pos       = 0;
      exp_q.delete();
    end else begin
      if (!mon_active && exp_q.size() > 0) begin
        mon_code   = exp_q.pop_front();
        mon_active = 1'b1;
        mon_pos    = 0;
      end
      if (mon_active) begin
        m_ec = exp_wave[mon_pos];
        m_eb = 1'b1;
        m_ed = 1'b0;
        mon_pos++;
        if (mon_pos == LEN) begin
          mon_active    = 1'b0;
          mon_done_next = 1'b1;
        end
      end else begin
        m_ec = 1'b0;
        m_eb = 1'b0;
        m_ed = mon_done_next;
        if (mon_done_next) $display("press code=%0d complete (t=%0t)", mon_code, $time);
        mon_done_next = 1'b0;
      end
      chk("contact", {7'd0, contact}, {7'd0, m_ec});
      chk("busy", {7'd0, busy}, {7'd0, m_eb});
      chk("key_ready", {7'd0, key_ready}, {7'd0, !m_eb});
      chk("done", {7'd0, done}, {7'd0, m_ed});
      chk("row", {4'd0, row}, {4'd0, exp_row(m_ec, mon_code, col)});
    end
  end

  // ---------------- stimulus ----------------
  int busy_left = 0;   // model: busy cycles still to come
  int scan_idx = 0;
  logic got_acc;

  task automatic drive_col(input int mode);
    logic [3:0] one;
    one = 4'b0001;
    case (mode)
      0: col = 4'hF;
      1: col = 4'h0;
      3: begin col = one << (scan_idx % 4); scan_idx++; end
      default: begin
        case ($urandom % 4)
          0: col = 4'hF;
          1: col = 4'h0;
          2: col = one << ($urandom % 4);
          default: col = 4'($urandom);
        endcase
      end
    endcase
  endtask

  // One clock cycle: decide acceptance from the model, push the expected
  // press at the edge, then drive new column value.
  task automatic cycle(input int mode);
    logic       acc;
    logic [3:0] c;
    @(negedge clk);
    acc = key_valid && (busy_left == 0) && !rst;
    c   = key_code;
    @(posedge clk);
    if (busy_left > 0) busy_left--;
    if (acc) begin
      exp_q.push_back(c);
      busy_left = LEN;
      $display("accept code=%0d (t=%0t)", c, $time);
    end
    got_acc = acc;
    #1;
    drive_col(mode);
  endtask

  task automatic press(input logic [3:0] code, input int mode);
    int n;
    key_valid = 1'b1;
    key_code  = code;
    drive_col(mode);
    n = 0;
    got_acc = 1'b0;
    while (!got_acc && n < 200) begin
      cycle(mode);
      n++;
    end
    if (!got_acc) chk("accept_timeout", 8'd0, 8'd1);
    key_valid = 1'b0;
    while (busy_left > 0) cycle(mode);
    cycle(mode);
  endtask

  initial begin
    int n;
    logic [3:0] one;
    int rows_on;
    one = 4'b0001;

    // Reset values, including row independent of col
    repeat (2) @(posedge clk);
    for (int i = 0; i < 4; i++) begin
      #1;
      col    = 4'($urandom);
      nb_col = 4'($urandom);
      #1;
      chk("rst_row", {4'd0, row}, 8'h0F);
      chk("rst_busy", {7'd0, busy}, 8'd0);
      chk("rst_ready", {7'd0, key_ready}, 8'd1);
      chk("rst_done", {7'd0, done}, 8'd0);
      chk("rst_contact", {7'd0, contact}, 8'd0);
      chk("rst_nb_row", {4'd0, nb_row}, 8'h0F);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    col = 4'hF;

    // Code 15, all columns driven
    press(4'd15, 0);
    // Code 6 with scanning columns
    press(4'd6, 3);

    // key_valid held continuously: codes 0 then 5 back to back
    key_valid = 1'b1;
    key_code  = 4'd0;
    n = 0;
    got_acc = 1'b0;
    while (!got_acc && n < 200) begin cycle(2); n++; end
    if (!got_acc) chk("accept_timeout", 8'd0, 8'd1);
    key_code = 4'd5;
    while (busy_left > 0) cycle(2);
    n = 0;
    got_acc = 1'b0;
    while (!got_acc && n < 200) begin cycle(2); n++; end
    if (!got_acc) chk("accept_timeout", 8'd0, 8'd1);
    key_valid = 1'b0;
    while (busy_left > 0) cycle(2);
    cycle(2);

    // Random traffic: valid toggling or held, code changing freely
    for (int i = 0; i < 500; i++) begin
      key_valid = ($urandom % 3) != 0;
      key_code  = 4'($urandom);
      cycle(2);
    end
    key_valid = 1'b0;
    while (busy_left > 0) cycle(2);
    cycle(2);

    // Code 0 with no column driven: row must stay idle
    press(4'd0, 1);

    // Reset during HOLD
    key_valid = 1'b1;
    key_code  = 4'($urandom);
    n = 0;
    got_acc = 1'b0;
    while (!got_acc && n < 200) begin cycle(0); n++; end
    key_valid = 1'b0;
    repeat (BOUNCE + 5) cycle(0);
    chk("hold_contact", {7'd0, contact}, 8'd1);
    #3 rst = 1'b1;
    #1;
    chk("arst_row", {4'd0, row}, 8'h0F);
    chk("arst_busy", {7'd0, busy}, 8'd0);
    chk("arst_ready", {7'd0, key_ready}, 8'd1);
    chk("arst_contact", {7'd0, contact}, 8'd0);
    busy_left = 0;
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (LEN + 4) cycle(0);   // monitor expects no done pulse

    // No-bounce instance: code 6, col fixed 0100 then scanned
    for (int t = 0; t < 2; t++) begin
      @(posedge clk);
      #1;
      nb_code  = 4'd6;
      nb_col   = 4'b0100;
      nb_valid = 1'b1;
      @(negedge clk);
      chk("nb_ready_idle", {7'd0, nb_ready}, 8'd1);
      @(posedge clk);
      #1 nb_valid = 1'b0;
      $display("nb accept code=6 col_mode=%0d (t=%0t)", t, $time);
      rows_on = 0;
      for (int k = 1; k <= LEN_NB + 2; k++) begin
        if (t == 1) nb_col = one << ((k - 1) % 4);
        @(negedge clk);
        if (nb_row == 4'b0010) rows_on++;
        chk("nb_row", {4'd0, nb_row},
            {4'd0, exp_row((k <= HOLD), 4'd6, nb_col)});
        chk("nb_contact", {7'd0, nb_contact}, {7'd0, (k <= HOLD)});
        chk("nb_done", {7'd0, nb_done}, {7'd0, (k == LEN_NB + 1)});
        chk("nb_busy", {7'd0, nb_busy}, {7'd0, (k <= LEN_NB)});
        @(posedge clk);
        #1;
      end
      if (t == 0) chk("nb_row_cycles", 8'(rows_on), 8'(HOLD));
      $display("nb press %0d complete, row active %0d cycles", t, rows_on);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
